baud_gen_frac: RTL and testbench

Parametrised fractional-N baud tick generator for the UART datapath, the successor to the integer-only baud generator. From a runtime divisor with integer and fractional parts it produces an oversampling tick `s_tick` for the RX/TX samplers, a bit-rate tick `b_tick` every OSR oversampling ticks, and the current oversample `phase`. It adds enable, synchronous restart and fractional error accumulation, so odd baud rates can be generated from any system clock without long-term drift.

---
 rtl/baud_pkg.sv | 15 +
 rtl/baud_frac_acc.sv | 30 +++
 rtl/baud_gen_frac.sv | 85 ++++++++
 tb/tb_baud_gen_frac.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// Shared constants, divisor types and width helper for the fractional baud generator.
package baud_pkg;

    localparam int BAUD_N   = 16;
    localparam int BAUD_F   = 4;
    localparam int BAUD_OSR = 16;

    typedef logic [BAUD_N-1:0] dvsr_int_t;
    typedef logic [BAUD_F-1:0] dvsr_frac_t;

    function automatic int phase_w(input int osr);
        return $clog2(osr);
    endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional error accumulator: adds dvsr_frac on every period wrap and flags
// (via carry) that the following period must be one cycle longer.
module baud_frac_acc
    import baud_pkg::*;
#(
    parameter int F = BAUD_F
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         step,
    input  logic [F-1:0] frac,
    output logic         carry
);

    logic [F-1:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (step) begin
            {carry, acc} <= {1'b0, acc} + {1'b0, frac};
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator: s_tick every dvsr_int+1(+frac) cycles,
// b_tick every OSR s_ticks. Macro BAUD_FRAC_EN compiles in the fractional part.
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int N   = BAUD_N,
    parameter int F   = BAUD_F,
    parameter int OSR = BAUD_OSR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      restart,
    input  logic [N-1:0]              dvsr_int,
    input  logic [F-1:0]              dvsr_frac,
    output logic                      s_tick,
    output logic                      b_tick,
    output logic [phase_w(OSR)-1:0]   phase
);

    localparam int            PW         = phase_w(OSR);
    localparam logic [PW-1:0] PHASE_LAST = PW'(OSR - 1);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
    localparam logic [N:0]    CNT_ONE    = (N + 1)'(1);

    // One extra bit so an all-ones dvsr_int extended by carry still counts to 2^N.
    logic [N:0] cnt;
    logic [N:0] lim;
    logic       carry;
    logic       wrap;

    assign lim  = {1'b0, dvsr_int} + {{N{1'b0}}, carry};
    assign wrap = (cnt >= lim);

`ifdef BAUD_FRAC_EN
    baud_frac_acc #(
        .F(F)
    ) u_frac_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (restart),
        .step  (en && wrap),
        .frac  (dvsr_frac),
        .carry (carry)
    );
`else
    logic unused_frac;
    assign carry       = 1'b0;
    assign unused_frac = ^dvsr_frac;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            phase  <= '0;
            s_tick <= 1'b0;
            b_tick <= 1'b0;
        end else if (restart) begin
            cnt    <= '0;
            phase  <= '0;
            s_tick <= 1'b0;
            b_tick <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt    <= '0;
                s_tick <= 1'b1;
                if (phase == PHASE_LAST) begin
                    phase  <= '0;
                    b_tick <= 1'b1;
                end else begin
                    phase  <= phase + PHASE_ONE;
                    b_tick <= 1'b0;
                end
            end else begin
                cnt    <= cnt + CNT_ONE;
                s_tick <= 1'b0;
                b_tick <= 1'b0;
            end
        end else begin
            s_tick <= 1'b0;
            b_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac; expectations follow BAUD_FRAC_EN when defined.
module tb_baud_gen_frac;

    logic        clk = 1'b0;
    logic        rst;

    logic        en_a, restart_a;
    logic [15:0] dvsr_int_a;
    logic [3:0]  dvsr_frac_a;
    logic        s_tick_a, b_tick_a;
    logic [1:0]  phase_a;

    logic        en_b, restart_b;
    logic [7:0]  dvsr_int_b;
    logic [3:0]  dvsr_frac_b;
    logic        s_tick_b, b_tick_b;
    logic [0:0]  phase_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start;
    logic sb_on  = 1'b0;

    logic [31:0] exp_q[$];
    int          tick_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    baud_gen_frac #(.N(16), .F(4), .OSR(4)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .restart(restart_a),
        .dvsr_int(dvsr_int_a), .dvsr_frac(dvsr_frac_a),
        .s_tick(s_tick_a), .b_tick(b_tick_a), .phase(phase_a)
    );

    baud_gen_frac #(.N(8), .F(4), .OSR(2)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .restart(restart_b),
        .dvsr_int(dvsr_int_b), .dvsr_frac(dvsr_frac_b),
        .s_tick(s_tick_b), .b_tick(b_tick_b), .phase(phase_b)
    );

    function automatic logic [31:0] mk(input int c, input logic b, input int ph);
        logic [31:0] r;
        r = {c[23:0], b, ph[6:0]};
        return r;
    endfunction

    // Scoreboard for dut_a: every s_tick pops one expected {cycle, b_tick, phase}.
    always @(negedge clk) begin
        if (sb_on && s_tick_a) begin
            logic [31:0] e;
            logic [31:0] o;
            tick_q.push_back(cyc);
            o = mk(cyc, b_tick_a, int'(phase_a));
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_tick: got cyc=%0d b=%0d ph=%0d, required no tick", cyc, b_tick_a, phase_a);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) $display("FAIL sb_tick: got %h, required %h (cyc,b,phase)", o, e);
                else n_pass++;
            end
        end
        if (sb_on && b_tick_a && !s_tick_a) begin
            n_checks++;
            $display("FAIL sb_btick_alone: got b_tick=1 s_tick=0 at cyc=%0d, required coincident", cyc);
        end
    end

    task automatic begin_test(input int di, input int df);
        @(negedge clk);
        en_a = 1'b0;
        restart_a = 1'b1;
        @(negedge clk);
        restart_a = 1'b0;
        dvsr_int_a = 16'(di);
        dvsr_frac_a = 4'(df);
        en_a = 1'b1;
        exp_q.delete();
        tick_q.delete();
        start = cyc;
        sb_on = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en_a = 1'b0; restart_a = 1'b0; dvsr_int_a = '0; dvsr_frac_a = '0;
        en_b = 1'b0; restart_b = 1'b0; dvsr_int_b = '0; dvsr_frac_b = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (s_tick_a !== 1'b0) $display("FAIL reset_s_tick: got %b, required 0", s_tick_a); else n_pass++;
        n_checks++;
        if (b_tick_a !== 1'b0) $display("FAIL reset_b_tick: got %b, required 0", b_tick_a); else n_pass++;
        n_checks++;
        if (phase_a !== 2'd0) $display("FAIL reset_phase: got %0d, required 0", phase_a); else n_pass++;
        n_checks++;
        if ({s_tick_b, b_tick_b, phase_b} !== 3'b000) $display("FAIL reset_dut_b: got %b, required 000", {s_tick_b, b_tick_b, phase_b}); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_integer();
        begin_test(3, 0);
        for (int k = 1; k <= 8; k++) exp_q.push_back(mk(start + 4 * k, (k % 4) == 0, k % 4));
        repeat (34) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL integer_missing: got %0d ticks outstanding, required 0", exp_q.size()); else n_pass++;
        sb_on = 1'b0;
    endtask

    task automatic test_fractional();
        int c, acc, s, t, sum_exp;
        begin_test(3, 8);
        c = 0; acc = 0; t = start;
        for (int k = 1; k <= 34; k++) begin
            t += 4 + c;
            exp_q.push_back(mk(t, (k % 4) == 0, k % 4));
`ifdef BAUD_FRAC_EN
            s = acc + 8;
            c = (s >= 16) ? 1 : 0;
            acc = s % 16;
`else
            s = 0;
            c = 0;
`endif
        end
`ifdef BAUD_FRAC_EN
        sum_exp = 144;
`else
        sum_exp = 128;
`endif
        repeat (t - start + 3) @(negedge clk);
        #1;
        n_checks++;
        if (tick_q.size() < 34) $display("FAIL frac_count: got %0d ticks, required 34", tick_q.size());
        else if (tick_q[33] - tick_q[1] != sum_exp) $display("FAIL frac_sum32: got %0d cycles, required %0d", tick_q[33] - tick_q[1], sum_exp);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL frac_missing: got %0d ticks outstanding, required 0", exp_q.size()); else n_pass++;
        sb_on = 1'b0;
    endtask

    task automatic test_enable_pause();
        begin_test(9, 8);
        exp_q.push_back(mk(start + 15, 1'b0, 1));
        exp_q.push_back(mk(start + 25, 1'b0, 2));
        repeat (4) @(negedge clk);
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (s_tick_a !== 1'b0 || b_tick_a !== 1'b0) $display("FAIL pause_quiet: got s=%b b=%b, required 0 0", s_tick_a, b_tick_a);
            else n_pass++;
        end
        en_a = 1'b1;
        repeat (18) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL pause_missing: got %0d ticks outstanding, required 0", exp_q.size()); else n_pass++;
        sb_on = 1'b0;
    endtask

    task automatic test_restart();
        int start2;
        begin_test(9, 0);
        exp_q.push_back(mk(start + 10, 1'b0, 1));
        exp_q.push_back(mk(start + 20, 1'b0, 2));
        repeat (25) @(negedge clk);
        n_checks++;
        if (phase_a !== 2'd2) $display("FAIL restart_pre_phase: got %0d, required 2", phase_a); else n_pass++;
        en_a = 1'b0;
        restart_a = 1'b1;
        @(negedge clk);
        restart_a = 1'b0;
        n_checks++;
        if ({s_tick_a, b_tick_a, phase_a} !== 4'b0000) $display("FAIL restart_clear: got %b, required 0000", {s_tick_a, b_tick_a, phase_a}); else n_pass++;
        repeat (2) @(negedge clk);
        en_a = 1'b1;
        start2 = cyc;
        exp_q.push_back(mk(start2 + 10, 1'b0, 1));
        repeat (13) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL restart_missing: got %0d ticks outstanding, required 0", exp_q.size()); else n_pass++;
        sb_on = 1'b0;
    endtask

    task automatic test_shrink();
        begin_test(100, 0);
        repeat (50) @(negedge clk);
        dvsr_int_a = 16'd5;
        exp_q.push_back(mk(start + 51, 1'b0, 1));
        exp_q.push_back(mk(start + 57, 1'b0, 2));
        exp_q.push_back(mk(start + 63, 1'b0, 3));
        exp_q.push_back(mk(start + 69, 1'b1, 0));
        repeat (21) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL shrink_missing: got %0d ticks outstanding, required 0", exp_q.size()); else n_pass++;
        sb_on = 1'b0;
    endtask

    task automatic test_async_reset();
        begin_test(3, 0);
        exp_q.push_back(mk(start + 4, 1'b0, 1));
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({s_tick_a, b_tick_a, phase_a} !== 4'b0000) $display("FAIL async_reset: got %b, required 0000", {s_tick_a, b_tick_a, phase_a}); else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL async_pre_tick: got %0d ticks outstanding, required 0", exp_q.size()); else n_pass++;
        sb_on = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_extremes();
        int prev, c, acc, s, p_exp;
        logic got;
        @(negedge clk);
        restart_b = 1'b1;
        @(negedge clk);
        restart_b = 1'b0;
        dvsr_int_b = 8'd0;
        dvsr_frac_b = 4'd0;
        en_b = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (s_tick_b !== 1'b1 || b_tick_b !== ((i % 2) == 0) || phase_b !== 1'(i % 2))
                $display("FAIL min_div_cycle%0d: got s=%b b=%b ph=%0d, required s=1 b=%0d ph=%0d", i, s_tick_b, b_tick_b, phase_b, (i % 2) == 0, i % 2);
            else n_pass++;
        end
        en_b = 1'b0;
        restart_b = 1'b1;
        @(negedge clk);
        restart_b = 1'b0;
        dvsr_int_b = 8'hff;
        dvsr_frac_b = 4'hf;
        en_b = 1'b1;
        prev = cyc;
        c = 0; acc = 0;
        for (int k = 0; k < 6; k++) begin
            p_exp = 256 + c;
            got = 1'b0;
            for (int w = 0; w < 300; w++) begin
                @(negedge clk);
                if (s_tick_b) begin
                    got = 1'b1;
                    break;
                end
            end
            n_checks++;
            if (!got) begin
                $display("FAIL max_div_timeout: got no s_tick within 300 cycles, required period %0d", p_exp);
                break;
            end
            if (cyc - prev != p_exp) $display("FAIL max_div_period%0d: got %0d, required %0d", k, cyc - prev, p_exp);
            else n_pass++;
            prev = cyc;
`ifdef BAUD_FRAC_EN
            s = acc + 15;
            c = (s >= 16) ? 1 : 0;
            acc = s % 16;
`else
            s = 0;
            c = 0;
`endif
        end
        en_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_integer();
        test_fractional();
        test_enable_pause();
        test_restart();
        test_shrink();
        test_async_reset();
        test_extremes();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
